// File: rtl/life_step_sequencer.sv
// life_step_sequencer: steps one Game of Life generation across a double-buffered grid.
// Define LIFE_WRAP_EN for a toroidal grid; without it, cells beyond the edge count as dead.
module life_step_sequencer #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int X_W    = 6,
    parameter int Y_W    = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           bank,
    output logic [7:0]     gen_count,
    output logic           rd_en,
    output logic [X_W-1:0] rd_x,
    output logic [Y_W-1:0] rd_y,
    input  logic           rd_data,
    output logic           wr_en,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic           wr_data,
    output logic           plot,
    output logic [X_W-1:0] plot_x,
    output logic [Y_W-1:0] plot_y,
    output logic           plot_colour,
    input  logic           plot_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_ACCUM, S_WRITE, S_PLOT_WAIT, S_NEXT, S_SWAP
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);
    localparam logic [X_W:0]   X_OUT  = (X_W+1)'(GRID_W + 1);
    localparam logic [Y_W:0]   Y_OUT  = (Y_W+1)'(GRID_H + 1);

    state_t         r_state, w_state_n;
    logic [1:0]     r_kx, r_ky, w_kx_n, w_ky_n;
    logic [X_W-1:0] r_x, w_x_n;
    logic [Y_W-1:0] r_y, w_y_n;
    logic [3:0]     r_cnt, w_cnt_n;
    logic           r_alive, w_alive_n;
    logic           r_pend, r_pend_c;
    logic           w_cell_n;

    logic           r_bank, w_bank_n;
    logic [7:0]     r_gen, w_gen_n;
    logic           r_done, w_done_n;
    logic           r_rd_en, w_rd_en_n;
    logic [X_W-1:0] r_rd_x, w_rd_x_n;
    logic [Y_W-1:0] r_rd_y, w_rd_y_n;
    logic           r_wr_en, w_wr_en_n;
    logic [X_W-1:0] r_wr_x, w_wr_x_n;
    logic [Y_W-1:0] r_wr_y, w_wr_y_n;
    logic           r_wr_data, w_wr_data_n;
    logic           r_plot, w_plot_n;
    logic [X_W-1:0] r_plot_x, w_plot_x_n;
    logic [Y_W-1:0] r_plot_y, w_plot_y_n;
    logic           r_plot_c, w_plot_c_n;

    logic [X_W:0]   w_vx;
    logic [Y_W:0]   w_vy;
    logic           w_nb_in;
    logic [X_W-1:0] w_nb_x;
    logic [Y_W-1:0] w_nb_y;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign bank        = r_bank;
    assign gen_count   = r_gen;
    assign rd_en       = r_rd_en;
    assign rd_x        = r_rd_x;
    assign rd_y        = r_rd_y;
    assign wr_en       = r_wr_en;
    assign wr_x        = r_wr_x;
    assign wr_y        = r_wr_y;
    assign wr_data     = r_wr_data;
    assign plot        = r_plot;
    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_c;

    // Sequencing, neighbour accumulation and next-cycle values of write/plot/bank outputs
    always_comb begin
        w_state_n   = r_state;
        w_kx_n      = r_kx;
        w_ky_n      = r_ky;
        w_x_n       = r_x;
        w_y_n       = r_y;
        w_cnt_n     = r_cnt;
        w_alive_n   = r_alive;
        w_bank_n    = r_bank;
        w_gen_n     = r_gen;
        w_wr_en_n   = 1'b0;
        w_wr_data_n = 1'b0;
        w_wr_x_n    = '0;
        w_wr_y_n    = '0;
        w_plot_n    = 1'b0;
        w_plot_x_n  = '0;
        w_plot_y_n  = '0;
        w_plot_c_n  = 1'b0;
        if (r_pend && rd_data) begin
            if (r_pend_c) w_alive_n = 1'b1;
            else          w_cnt_n   = r_cnt + 4'd1;
        end
        w_cell_n = (w_cnt_n == 4'd3) || (w_alive_n && (w_cnt_n == 4'd2));
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_READ;
                    w_kx_n    = '0;
                    w_ky_n    = '0;
                    w_x_n     = '0;
                    w_y_n     = '0;
                    w_cnt_n   = '0;
                    w_alive_n = 1'b0;
                end
            end
            S_READ: begin
                if (r_kx == 2'd2) begin
                    w_kx_n = '0;
                    if (r_ky == 2'd2) begin
                        w_ky_n    = '0;
                        w_state_n = S_ACCUM;
                    end else begin
                        w_ky_n = r_ky + 2'd1;
                    end
                end else begin
                    w_kx_n = r_kx + 2'd1;
                end
            end
            S_ACCUM: begin
                w_state_n   = S_WRITE;
                w_wr_en_n   = 1'b1;
                w_wr_data_n = w_cell_n;
                w_wr_x_n    = r_x;
                w_wr_y_n    = r_y;
                if (w_cell_n != w_alive_n) begin
                    w_plot_n   = 1'b1;
                    w_plot_x_n = r_x;
                    w_plot_y_n = r_y;
                    w_plot_c_n = w_cell_n;
                end
            end
            S_WRITE, S_PLOT_WAIT: begin
                if (r_plot && !plot_ready) begin
                    w_state_n  = S_PLOT_WAIT;
                    w_plot_n   = 1'b1;
                    w_plot_x_n = r_plot_x;
                    w_plot_y_n = r_plot_y;
                    w_plot_c_n = r_plot_c;
                end else begin
                    w_state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                w_cnt_n   = '0;
                w_alive_n = 1'b0;
                w_state_n = S_READ;
                if (r_x == X_LAST) begin
                    w_x_n = '0;
                    if (r_y == Y_LAST) begin
                        w_y_n     = '0;
                        w_state_n = S_SWAP;
                        w_bank_n  = ~r_bank;
                        w_gen_n   = r_gen + 8'd1;
                    end else begin
                        w_y_n = r_y + 1'b1;
                    end
                end else begin
                    w_x_n = r_x + 1'b1;
                end
            end
            S_SWAP:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        w_done_n = (w_state_n == S_SWAP);
    end

    // Neighbour address for the next read: offsets are kx-1, ky-1 around the cell
    always_comb begin
        w_vx   = {1'b0, w_x_n} + (X_W+1)'(w_kx_n);
        w_vy   = {1'b0, w_y_n} + (Y_W+1)'(w_ky_n);
        w_nb_x = X_W'(w_vx - 1'b1);
        w_nb_y = Y_W'(w_vy - 1'b1);
`ifdef LIFE_WRAP_EN
        w_nb_in = 1'b1;
        if (w_vx == '0)        w_nb_x = X_LAST;
        else if (w_vx == X_OUT) w_nb_x = '0;
        if (w_vy == '0)        w_nb_y = Y_LAST;
        else if (w_vy == Y_OUT) w_nb_y = '0;
`else
        w_nb_in = (w_vx != '0) && (w_vx != X_OUT)
               && (w_vy != '0) && (w_vy != Y_OUT);
`endif
        w_rd_en_n = (w_state_n == S_READ) && w_nb_in;
        w_rd_x_n  = w_rd_en_n ? w_nb_x : '0;
        w_rd_y_n  = w_rd_en_n ? w_nb_y : '0;
    end

    // State, cell position and registered outputs; rd_data is tagged one cycle behind rd_en
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_kx      <= '0;
            r_ky      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_alive   <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_c  <= 1'b0;
            r_bank    <= 1'b0;
            r_gen     <= '0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_x    <= '0;
            r_rd_y    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_wr_data <= 1'b0;
            r_plot    <= 1'b0;
            r_plot_x  <= '0;
            r_plot_y  <= '0;
            r_plot_c  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_kx      <= w_kx_n;
            r_ky      <= w_ky_n;
            r_x       <= w_x_n;
            r_y       <= w_y_n;
            r_cnt     <= w_cnt_n;
            r_alive   <= w_alive_n;
            r_pend    <= r_rd_en;
            r_pend_c  <= (r_state == S_READ) && (r_kx == 2'd1) && (r_ky == 2'd1);
            r_bank    <= w_bank_n;
            r_gen     <= w_gen_n;
            r_done    <= w_done_n;
            r_rd_en   <= w_rd_en_n;
            r_rd_x    <= w_rd_x_n;
            r_rd_y    <= w_rd_y_n;
            r_wr_en   <= w_wr_en_n;
            r_wr_x    <= w_wr_x_n;
            r_wr_y    <= w_wr_y_n;
            r_wr_data <= w_wr_data_n;
            r_plot    <= w_plot_n;
            r_plot_x  <= w_plot_x_n;
            r_plot_y  <= w_plot_y_n;
            r_plot_c  <= w_plot_c_n;
        end
    end

endmodule

// File: tb/tb_life_step_sequencer.sv
// tb_life_step_sequencer: grid RAM model, reference Life model and plot scoreboard.
// Runs a reduced 14x17 grid; honours LIFE_WRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_life_step_sequencer;

    localparam int W  = 14;
    localparam int H  = 17;
    localparam int XW = 4;
    localparam int YW = 5;
    localparam int GEN_CYC = 12 * W * H + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, bank;
    logic [7:0]    gen_count;
    logic          rd_en, rd_data;
    logic [XW-1:0] rd_x, wr_x, plot_x;
    logic [YW-1:0] rd_y, wr_y, plot_y;
    logic          wr_en, wr_data, plot, plot_colour;
    logic          plot_ready;

    life_step_sequencer #(.GRID_W(W), .GRID_H(H), .X_W(XW), .Y_W(YW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .bank(bank), .gen_count(gen_count),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot_ready(plot_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Grid RAM: two banks, read latency 1, bench-side clear/load port
    logic [W-1:0]  mem [2][H];
    logic          tb_clr = 1'b0;
    logic          tb_ld = 1'b0;
    logic          tb_ld_b = 1'b0;
    logic [XW-1:0] tb_ld_x = '0;
    logic [YW-1:0] tb_ld_y = '0;

    always @(posedge clock) begin
        if (tb_clr) begin
            for (int b = 0; b < 2; b++)
                for (int yy = 0; yy < H; yy++)
                    mem[b][yy] <= '0;
        end else if (tb_ld) begin
            mem[tb_ld_b][tb_ld_y][tb_ld_x] <= 1'b1;
        end else if (wr_en) begin
            mem[~bank][wr_y][wr_x] <= wr_data;
        end
        if (rd_en) rd_data <= mem[bank][rd_y][rd_x];
        else       rd_data <= 1'($urandom);
    end

    // Reference model and scoreboard
    typedef struct { int x; int y; bit c; } plot_t;
    plot_t        sb[$];
    logic [W-1:0] mg [H];
    logic [W-1:0] ng [H];
    logic         exp_bank = 1'b0;
    logic [7:0]   exp_gen = '0;

    function automatic int live(input int x, input int y);
`ifdef LIFE_WRAP_EN
        x = (x + W) % W;
        y = (y + H) % H;
`else
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
`endif
        return int'(mg[y][x]);
    endfunction

    function automatic int model_step();
        int n, nch;
        bit c, nx;
        nch = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) n += live(x + dx, y + dy);
                c  = mg[y][x];
                nx = (n == 3) || (c && n == 2);
                ng[y][x] = nx;
                if (nx != c) begin
                    sb.push_back('{x, y, nx});
                    nch++;
                end
            end
        end
        return nch;
    endfunction

    // Plot sink: stalls each request, checks held payload, pops scoreboard on accept
    int stall = 0;
    int n_plots = 0;
    initial begin
        int    wcnt;
        bit    held;
        int    hx, hy, hc;
        plot_t e;
        wcnt = 0;
        held = 0;
        hx = 0; hy = 0; hc = 0;
        plot_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (held) begin
                check("plot_hold", plot, 1);
                check("plot_hold_x", plot_x, hx);
                check("plot_hold_y", plot_y, hy);
                check("plot_hold_c", plot_colour, hc);
            end
            if (!plot) begin
                wcnt = 0;
                held = 0;
                plot_ready = (stall == 0);
            end else begin
                if (wcnt < stall) begin
                    plot_ready = 1'b0;
                    wcnt++;
                end else begin
                    plot_ready = 1'b1;
                end
                if (plot_ready) begin
                    held = 0;
                    n_plots++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL plot_pop actual=(%0d,%0d) required=no_plot",
                                 plot_x, plot_y);
                    end else begin
                        e = sb.pop_front();
                        check("plot_x", plot_x, e.x);
                        check("plot_y", plot_y, e.y);
                        check("plot_colour", plot_colour, e.c);
                    end
                end else begin
                    held = 1;
                    hx = int'(plot_x);
                    hy = int'(plot_y);
                    hc = int'(plot_colour);
                end
            end
        end
    end

    task automatic set_cell(input int x, input int y);
        mg[y][x] = 1'b1;
        @(negedge clock);
        tb_ld   = 1'b1;
        tb_ld_b = exp_bank;
        tb_ld_x = XW'(x);
        tb_ld_y = YW'(y);
        @(negedge clock);
        tb_ld = 1'b0;
    endtask

    task automatic load_pat(input int pat);
        @(negedge clock);
        tb_clr = 1'b1;
        @(negedge clock);
        tb_clr = 1'b0;
        for (int y = 0; y < H; y++) mg[y] = '0;
        case (pat)
            0: begin set_cell(10, 15); set_cell(11, 15); set_cell(12, 15); end
            1: begin set_cell(5, 5); set_cell(6, 5); set_cell(5, 6); set_cell(6, 6); end
            default: begin set_cell(W - 1, 0); set_cell(0, 0); set_cell(1, 0); end
        endcase
    endtask

    task automatic run_gen(input int stl, input int pulse_at,
                           output int lat, output int nplot);
        int ecount, bad;
        stall = stl;
        sb.delete();
        ecount = model_step();
        n_plots = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        check("busy_after_start", busy, 1);
        while (!done && lat < 3 * GEN_CYC) begin
            @(negedge clock);
            lat++;
            start = (lat == pulse_at);
        end
        start = 1'b0;
        nplot = n_plots;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL gen_timeout actual=%0d cycles required=done", lat);
        end
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 8'd1;
        check("latency", lat, GEN_CYC + stl * ecount);
        check("plot_count", nplot, ecount);
        check("sb_left", sb.size(), 0);
        check("bank", bank, exp_bank);
        check("gen_count", gen_count, exp_gen);
        @(negedge clock);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        bad = 0;
        for (int y = 0; y < H; y++)
            if (mem[exp_bank][y] !== ng[y]) bad++;
        check("grid_rows_bad", bad, 0);
        for (int y = 0; y < H; y++) mg[y] = ng[y];
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bank", bank, 0);
        check("rst_gen", gen_count, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_plot", plot, 0);
        check("rst_coords", {rd_x, rd_y, wr_x, wr_y, plot_x, plot_y}, 0);
        check("rst_data", {wr_data, plot_colour}, 0);
    endtask

    typedef struct { int pat; int stl; int exp_plots; int exp_lat; } vec_t;

    initial begin
        vec_t tbl[3];
        int   lat, np, live_n;
        tbl[0] = '{0, 0, 4, GEN_CYC};
        tbl[1] = '{1, 0, 0, GEN_CYC};
        tbl[2] = '{0, 5, 4, GEN_CYC + 20};

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            load_pat(tbl[i].pat);
            run_gen(tbl[i].stl, 0, lat, np);
            check($sformatf("tbl%0d_plots", i), np, tbl[i].exp_plots);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
        end
        check("blinker_vert", {mem[exp_bank][14][11], mem[exp_bank][15][11],
                               mem[exp_bank][16][11], mem[exp_bank][15][10],
                               mem[exp_bank][15][12]}, 5'b11100);

        load_pat(2);
        for (int g = 0; g < 10; g++) begin
            run_gen(0, 0, lat, np);
            live_n = 0;
            for (int y = 0; y < H; y++) live_n += $countones(mem[exp_bank][y]);
`ifdef LIFE_WRAP_EN
            check($sformatf("edge_wrap_live_g%0d", g + 1), live_n, 3);
`else
            if (g == 0) check("edge_dead_live", live_n, 0);
`endif
        end

        load_pat(0);
        run_gen(0, 100, lat, np);
        check("ignored_start_latency", lat, GEN_CYC);

        load_pat(0);
        stall = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (1500) @(negedge clock);
        check("busy_before_abort", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;
        exp_bank = 1'b0;
        exp_gen  = '0;
        sb.delete();

        load_pat(0);
        run_gen(0, 0, lat, np);
        check("restart_plots", np, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
